cic_byte_serializer: RTL and testbench

Downstream stage of the CIC decimator. Takes each decimated output sample (one-cycle `in_valid` strobe, no backpressure), buffers it in a small FIFO, and streams it MSB-byte-first over an 8-bit valid/ready byte port feeding the chip's dedicated outputs. A sticky overflow flag records samples dropped because the FIFO was full.

---
 rtl/cic_byte_serializer.sv | 160 ++++++++++++++++
 tb/tb_cic_byte_serializer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cic_byte_serializer.sv
// cic_byte_serializer: buffers decimated CIC samples in a small circular FIFO
// and streams each one MSB byte first over an 8-bit valid/ready byte port.
// Samples that arrive while the FIFO is full and not draining are dropped,
// and a sticky overflow flag records that this happened.

module cic_byte_serializer #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    in_valid,
    output logic [7:0]              out_byte,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_first,
    output logic                    overflow,
    input  logic                    clear_ovf,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int NBYTES = DATA_W / 8;
    localparam int AW     = $clog2(DEPTH);
    localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int LAST   = NBYTES - 1;

    localparam logic [IW-1:0] LAST_IDX   = LAST[IW-1:0];
    localparam logic [AW:0]   FULL_LEVEL = DEPTH[AW:0];

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] shifted;
    logic [IW-1:0]     byte_idx;

    logic fifo_empty;
    logic fifo_full;
    logic xfer;
    logic last_xfer;
    logic pop;
    logic push;
    logic drop;

    // The FIFO is popped whenever the shift register is free to take a new
    // sample: either nothing is in flight, or its last byte leaves this
    // cycle. A full FIFO still accepts a sample if a pop frees a slot in the
    // same cycle; otherwise the sample is dropped.
    assign fifo_empty = (level == '0);
    assign fifo_full  = (level == FULL_LEVEL);
    assign head       = mem[rd_ptr];
    assign shifted    = shift_reg << 8;
    assign xfer       = (state == SEND) && out_ready;
    assign last_xfer  = xfer && (byte_idx == LAST_IDX);
    assign pop        = !fifo_empty && ((state == IDLE) || last_xfer);
    assign push       = in_valid && (!fifo_full || pop);
    assign drop       = in_valid && fifo_full && !pop;

    // Sample storage; contents are only meaningful between the pointers, so
    // no reset is needed here.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Circular-buffer pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clear_ovf) begin
            overflow <= 1'b0;
        end
    end

    // Serializer FSM: loads a sample from the FIFO and shifts it out one
    // byte per accepted transfer, reloading back-to-back without a gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            byte_idx  <= '0;
            out_valid <= 1'b0;
            out_byte  <= 8'h00;
            out_first <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        shift_reg <= head;
                        byte_idx  <= '0;
                        out_byte  <= head[DATA_W-1 -: 8];
                        out_valid <= 1'b1;
                        out_first <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (xfer) begin
                        if (byte_idx == LAST_IDX) begin
                            if (pop) begin
                                shift_reg <= head;
                                byte_idx  <= '0;
                                out_byte  <= head[DATA_W-1 -: 8];
                                out_valid <= 1'b1;
                                out_first <= 1'b1;
                            end else begin
                                out_valid <= 1'b0;
                                out_first <= 1'b0;
                                state     <= IDLE;
                            end
                        end else begin
                            shift_reg <= shifted;
                            byte_idx  <= byte_idx + 1'b1;
                            out_byte  <= shifted[DATA_W-1 -: 8];
                            out_first <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    out_first <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cic_byte_serializer.sv
// Testbench for cic_byte_serializer: a directed vector table, hand-written
// multi-cycle scenarios and a randomized run, all checked against a
// queue-based reference model of the byte stream, FIFO and overflow flag.

module tb_cic_byte_serializer;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;
    localparam int NBYTES = DATA_W / 8;
    localparam int LW     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic [7:0]        out_byte;
    logic              out_valid;
    logic              out_ready;
    logic              out_first;
    logic              overflow;
    logic              clear_ovf;
    logic [LW-1:0]     level;

    int checks   = 0;
    int failures = 0;

    // Reference model state: samples waiting in the FIFO, bytes of the
    // sample currently being sent, and the sticky overflow flag.
    logic [DATA_W-1:0] m_fifo [$];
    logic [7:0]        m_cur  [$];
    bit                m_ovf;

    cic_byte_serializer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_byte  (out_byte),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_first (out_first),
        .overflow  (overflow),
        .clear_ovf (clear_ovf),
        .level     (level)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    typedef struct {
        bit          v;
        logic [15:0] d;
        bit          rdy;
        bit          ev;
        logic [7:0]  eb;
        bit          ef;
        int          el;
        bit          eo;
    } vec_t;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic checkModel(input string tag);
        bit exp_valid;
        exp_valid = (m_cur.size() != 0);
        checkOutput($sformatf("%s_valid", tag), 32'(out_valid), 32'(exp_valid));
        checkOutput($sformatf("%s_first", tag), 32'(out_first), 32'(m_cur.size() == NBYTES));
        checkOutput($sformatf("%s_level", tag), 32'(level), 32'(m_fifo.size()));
        checkOutput($sformatf("%s_ovf", tag), 32'(overflow), 32'(m_ovf));
        if (exp_valid) begin
            checkOutput($sformatf("%s_byte", tag), 32'(out_byte), 32'(m_cur[0]));
        end
    endtask

    // Drive one cycle of inputs, advance the reference model by the
    // behavioural rules, then wait until just after the next rising edge.
    task automatic applyStimulus(input bit v, input logic [DATA_W-1:0] d,
                                 input bit rdy, input bit clr, input bit r);
        bit xfer;
        bit pop;
        bit full;
        bit push;
        bit drop;
        logic [DATA_W-1:0] s;
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        clear_ovf = clr;
        rst       = r;
        if (r) begin
            m_fifo.delete();
            m_cur.delete();
            m_ovf = 1'b0;
        end else begin
            xfer = (m_cur.size() != 0) && rdy;
            pop  = (m_fifo.size() != 0) && ((m_cur.size() == 0) || (xfer && m_cur.size() == 1));
            full = (m_fifo.size() == DEPTH);
            push = v && (!full || pop);
            drop = v && full && !pop;
            if (xfer) begin
                void'(m_cur.pop_front());
            end
            if (pop) begin
                s = m_fifo.pop_front();
                for (int b = 0; b < NBYTES; b++) begin
                    m_cur.push_back(s[DATA_W-1-8*b -: 8]);
                end
            end
            if (push) begin
                m_fifo.push_back(d);
            end
            if (drop) begin
                m_ovf = 1'b1;
            end else if (clr) begin
                m_ovf = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t vecs [11];
        logic [7:0] got [$];
        logic [7:0] want [$];
        bit rdy;

        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        clear_ovf = 1'b0;
        rst       = 1'b1;
        m_ovf     = 1'b0;

        // Reset state.
        applyStimulus(0, '0, 0, 0, 1);
        applyStimulus(0, '0, 0, 0, 1);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_out_byte", 32'(out_byte), 32'd0);
        checkOutput("reset_out_first", 32'(out_first), 32'd0);
        checkOutput("reset_overflow", 32'(overflow), 32'd0);
        checkOutput("reset_level", 32'(level), 32'd0);

        // Directed table: single sample, then two samples two cycles apart.
        vecs[0]  = '{1'b1, 16'hA5C3, 1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b0};
        vecs[1]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b0, 1, 1'b0};
        vecs[2]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 8'hA5, 1'b1, 0, 1'b0};
        vecs[3]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 8'hC3, 1'b0, 0, 1'b0};
        vecs[4]  = '{1'b1, 16'h1234, 1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b0};
        vecs[5]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b0, 1, 1'b0};
        vecs[6]  = '{1'b1, 16'h5678, 1'b1, 1'b1, 8'h12, 1'b1, 0, 1'b0};
        vecs[7]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 8'h34, 1'b0, 1, 1'b0};
        vecs[8]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 8'h56, 1'b1, 0, 1'b0};
        vecs[9]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 8'h78, 1'b0, 0, 1'b0};
        vecs[10] = '{1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b0};
        for (int i = 0; i < 11; i++) begin
            checkOutput($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].ev));
            checkOutput($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].el));
            checkOutput($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].eo));
            if (vecs[i].ev) begin
                checkOutput($sformatf("vec%0d_byte", i), 32'(out_byte), 32'(vecs[i].eb));
                checkOutput($sformatf("vec%0d_first", i), 32'(out_first), 32'(vecs[i].ef));
            end
            applyStimulus(vecs[i].v, vecs[i].d, vecs[i].rdy, 0, 0);
        end

        // Backpressure: byte must hold while the consumer stalls.
        applyStimulus(1, 16'hA5C3, 0, 0, 0);
        applyStimulus(0, '0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_hold_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_hold_byte", 32'(out_byte), 32'hA5);
            applyStimulus(0, '0, 0, 0, 0);
        end
        checkOutput("bp_rel_byte0", 32'(out_byte), 32'hA5);
        checkOutput("bp_rel_first0", 32'(out_first), 32'd1);
        applyStimulus(0, '0, 1, 0, 0);
        checkOutput("bp_rel_byte1", 32'(out_byte), 32'hC3);
        checkOutput("bp_rel_first1", 32'(out_first), 32'd0);
        applyStimulus(0, '0, 1, 0, 0);
        checkOutput("bp_done_valid", 32'(out_valid), 32'd0);

        // Overflow: six samples into a stalled stream, the sixth is dropped.
        for (int i = 1; i <= 6; i++) begin
            checkModel("ovf_fill");
            applyStimulus(1, DATA_W'(i), 0, 0, 0);
        end
        checkOutput("ovf_flag", 32'(overflow), 32'd1);
        checkOutput("ovf_level", 32'(level), 32'd4);
        got.delete();
        for (int i = 0; i < 20; i++) begin
            checkModel("ovf_drain");
            if (out_valid) begin
                got.push_back(out_byte);
            end
            applyStimulus(0, '0, 1, 0, 0);
        end
        checkOutput("ovf_drain_count", 32'(got.size()), 32'd10);
        for (int i = 0; i < 10 && i < got.size(); i++) begin
            checkOutput($sformatf("ovf_drain_byte%0d", i), 32'(got[i]),
                        (i % 2 == 0) ? 32'h00 : 32'(i / 2 + 1));
        end
        checkOutput("ovf_still_set", 32'(overflow), 32'd1);
        applyStimulus(0, '0, 1, 1, 0);
        checkOutput("ovf_cleared", 32'(overflow), 32'd0);

        // Full FIFO accepts a sample when the last byte leaves the same cycle.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, DATA_W'(16'h0011 + i), 0, 0, 0);
        end
        checkOutput("sim_full_level", 32'(level), 32'd4);
        checkOutput("sim_first_byte", 32'(out_byte), 32'h00);
        applyStimulus(0, '0, 1, 0, 0);
        checkOutput("sim_last_byte", 32'(out_byte), 32'h11);
        applyStimulus(1, 16'h0016, 1, 0, 0);
        checkOutput("sim_ovf", 32'(overflow), 32'd0);
        checkOutput("sim_level", 32'(level), 32'd4);
        got.delete();
        for (int i = 0; i < 16; i++) begin
            checkModel("sim_drain");
            if (out_valid) begin
                got.push_back(out_byte);
            end
            applyStimulus(0, '0, 1, 0, 0);
        end
        want = '{8'h00, 8'h12, 8'h00, 8'h13, 8'h00, 8'h14, 8'h00, 8'h15, 8'h00, 8'h16};
        checkOutput("sim_drain_count", 32'(got.size()), 32'(want.size()));
        for (int i = 0; i < want.size() && i < got.size(); i++) begin
            checkOutput($sformatf("sim_drain_byte%0d", i), 32'(got[i]), 32'(want[i]));
        end

        // Reset while the second byte of a sample is pending.
        applyStimulus(1, 16'hBEEF, 1, 0, 0);
        applyStimulus(0, '0, 1, 0, 0);
        checkOutput("rst_msb", 32'(out_byte), 32'hBE);
        applyStimulus(1, 16'h7777, 1, 0, 0);
        checkOutput("rst_pending_byte", 32'(out_byte), 32'hEF);
        checkOutput("rst_pending_level", 32'(level), 32'd1);
        applyStimulus(0, '0, 0, 0, 1);
        checkOutput("rst_mid_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_mid_level", 32'(level), 32'd0);
        checkOutput("rst_mid_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, '0, 1, 0, 0);
            checkOutput("rst_no_stale", 32'(out_valid), 32'd0);
        end

        // Randomized run against the reference model; the second half
        // pushes harder so the FIFO fills and drops occur.
        for (int i = 0; i < 600; i++) begin
            checkModel("rand");
            rdy = ($urandom_range(0, 3) != 0);
            applyStimulus((i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 0),
                          DATA_W'($urandom), rdy,
                          ($urandom_range(0, 15) == 0), ($urandom_range(0, 199) == 0));
        end
        checkModel("rand_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
